// File: rtl/result_select_pkg.sv
`default_nettype none
// ============================================================================
// result_select_pkg : shared defaults and beat type for result_select_stage
// Rev 1.0
// ============================================================================
package result_select_pkg;

  localparam int RS_WIDTH_DEFAULT = 32;
  localparam int RS_N_IN_DEFAULT  = 3;

  // Substituted for the data word when the select is out of range
  localparam logic [RS_WIDTH_DEFAULT-1:0] RS_ERR_DATA = '0;

  typedef struct packed {
    logic [RS_WIDTH_DEFAULT-1:0] data;
    logic                        err;
  } rs_beat_t;

endpackage
`default_nettype wire

// File: rtl/rs_skid_buffer.sv
`default_nettype none
// ============================================================================
// rs_skid_buffer : 2-entry valid/ready buffer (main + skid) over a beat type
// Rev 1.0
// ============================================================================
module rs_skid_buffer
  import result_select_pkg::*;
#(
  parameter type beat_t = rs_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_valid_q, main_valid_d;
  logic  full_q, full_d;
  logic  accept;
  logic  emit;

  always_comb begin
    accept       = in_valid && !full_q;
    emit         = main_valid_q && out_ready;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    full_d       = full_q;

    // full_q implies main is valid and no accept can happen this cycle
    if (full_q) begin
      if (emit) begin
        main_d = skid_q;
        full_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && emit) begin
        main_d = in_beat;
      end else if (accept) begin
        skid_d = in_beat;
        full_d = 1'b1;
      end else if (emit) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_d       = in_beat;
      main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      full_q       <= full_d;
    end
  end

  // in_ready comes straight from a flop so out_ready never reaches it combinationally
  assign in_ready  = !full_q;
  assign out_valid = main_valid_q;
  assign out_beat  = main_q;

endmodule
`default_nettype wire

// File: rtl/result_select_stage.sv
`default_nettype none
// ============================================================================
// result_select_stage : N-way result select feeding a registered skid output
// Rev 1.0
// ============================================================================
module result_select_stage
  import result_select_pkg::*;
#(
  parameter int WIDTH = RS_WIDTH_DEFAULT,
  parameter int N_IN  = RS_N_IN_DEFAULT,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  beat_t sel_beat;
  beat_t out_beat;

  // Default is the error beat; any in-range match overrides it, so every select is defined
  always_comb begin
    sel_beat.data = WIDTH'(RS_ERR_DATA);
    sel_beat.err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_beat.data = in_data[k*WIDTH +: WIDTH];
        sel_beat.err  = 1'b0;
      end
    end
  end

  rs_skid_buffer #(
    .beat_t (beat_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_beat   (sel_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (out_beat)
  );

  assign out_data = out_beat.data;
  assign out_err  = out_beat.err;

endmodule
`default_nettype wire

// File: tb/tb_result_select_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_result_select_stage : scoreboard bench for result_select_stage
// Rev 1.0
// ============================================================================
module tb_result_select_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: WIDTH=32, N_IN=3
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [1:0]  a_in_sel;
  logic [95:0] a_in_data;
  logic [31:0] a_out_data;

  // Instance B: WIDTH=32, N_IN=4
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [1:0]   b_in_sel;
  logic [127:0] b_in_data;
  logic [31:0]  b_out_data;

  // Instance C: WIDTH=16, N_IN=5
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [2:0]  c_in_sel;
  logic [79:0] c_in_data;
  logic [15:0] c_out_data;

  result_select_stage #(.WIDTH(32), .N_IN(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err));

  result_select_stage #(.WIDTH(32), .N_IN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err));

  result_select_stage #(.WIDTH(16), .N_IN(5)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_sel(c_in_sel), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err));

  typedef struct { logic [31:0] d; logic e; } exp32_t;
  typedef struct { logic [15:0] d; logic e; } exp16_t;
  exp32_t qa[$];
  exp16_t qc[$];

  function automatic exp32_t model_a(input logic [1:0] sel, input logic [95:0] data);
    exp32_t r;
    case (sel)
      2'd0:    begin r.d = data[31:0];  r.e = 1'b0; end
      2'd1:    begin r.d = data[63:32]; r.e = 1'b0; end
      2'd2:    begin r.d = data[95:64]; r.e = 1'b0; end
      default: begin r.d = 32'h0;       r.e = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic exp16_t model_c(input logic [2:0] sel, input logic [79:0] data);
    exp16_t r;
    int s;
    s = int'(sel);
    if (s < 5) begin
      r.d = data[s*16 +: 16];
      r.e = 1'b0;
    end else begin
      r.d = 16'h0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  // Head of the A scoreboard; an empty queue yields X so any beat miscompares
  function automatic exp32_t pop_a();
    exp32_t r;
    if (qa.size() == 0) begin
      r.d = 'x;
      r.e = 1'bx;
    end else begin
      r = qa.pop_front();
    end
    return r;
  endfunction

  // Drive A for one cycle starting at a negedge; reports the handshakes seen at the next posedge
  task automatic a_cycle(input logic v, input logic [1:0] sel, input logic [95:0] data,
                         input logic rdy, output logic acc, output logic emit,
                         output logic [31:0] od, output logic oe);
    a_in_valid  = v;
    a_in_sel    = sel;
    a_in_data   = data;
    a_out_ready = rdy;
    acc  = v && a_in_ready;
    emit = a_out_valid && rdy;
    od   = a_out_data;
    oe   = a_out_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec += 4;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    if (a_in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    if (a_out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", a_out_data); end
    if (a_out_err !== 1'b0)   begin n_err++; $display("FAIL reset_out_err: got %b expected 0", a_out_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_through();
    logic [95:0] d;
    logic acc, emit, oe;
    logic [31:0] od;
    exp32_t ex;
    d = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL pass_in_ready[%0d]: got %b expected 1", i, a_in_ready); end
      a_cycle(i < 3, 2'(i % 3), d, 1'b1, acc, emit, od, oe);
      if (i >= 1 && i <= 3) begin
        n_vec++;
        if (emit !== 1'b1) begin n_err++; $display("FAIL pass_latency[%0d]: out_valid %b expected 1", i, emit); end
      end
      if (emit) begin
        ex = pop_a();
        n_vec++;
        if (od !== ex.d || oe !== ex.e) begin
          n_err++; $display("FAIL pass_beat[%0d]: got %h/%b expected %h/%b", i, od, oe, ex.d, ex.e);
        end
      end
      if (acc) qa.push_back(model_a(2'(i % 3), d));
    end
    n_vec++;
    if (qa.size() != 0) begin n_err++; $display("FAIL pass_drain: %0d beats left expected 0", qa.size()); end
  endtask

  task automatic test_out_of_range();
    logic [95:0] d;
    logic acc, emit, oe;
    logic [31:0] od;
    exp32_t ex;
    d = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678};
    a_cycle(1'b1, 2'd3, d, 1'b1, acc, emit, od, oe);
    if (acc) qa.push_back(model_a(2'd3, d));
    a_cycle(1'b0, 2'd0, d, 1'b1, acc, emit, od, oe);
    ex = pop_a();
    n_vec += 3;
    if (emit !== 1'b1) begin n_err++; $display("FAIL oor_emit: got %b expected 1", emit); end
    if (od !== ex.d || oe !== ex.e) begin
      n_err++; $display("FAIL oor_beat: got %h/%b expected %h/%b", od, oe, ex.d, ex.e);
    end
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL oor_single_beat: out_valid %b expected 0", a_out_valid); end

    // Same select on a 4-input stage is in range
    b_in_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b_in_sel   = 2'd3;
    b_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    n_vec += 3;
    if (b_out_valid !== 1'b1)         begin n_err++; $display("FAIL n4_valid: got %b expected 1", b_out_valid); end
    if (b_out_data !== 32'h44444444)  begin n_err++; $display("FAIL n4_data: got %h expected 44444444", b_out_data); end
    if (b_out_err !== 1'b0)           begin n_err++; $display("FAIL n4_err: got %b expected 0", b_out_err); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [95:0] d;
    logic acc, emit, oe;
    logic [31:0] od;
    logic c_taken;
    exp32_t ex;
    d = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    a_cycle(1'b1, 2'd0, d, 1'b0, acc, emit, od, oe);
    n_vec++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL bp_accept_A: got %b expected 1", acc); end
    if (acc) qa.push_back(model_a(2'd0, d));
    a_cycle(1'b1, 2'd1, d, 1'b0, acc, emit, od, oe);
    n_vec++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL bp_accept_B: got %b expected 1", acc); end
    if (acc) qa.push_back(model_a(2'd1, d));
    for (int i = 0; i < 2; i++) begin
      a_cycle(1'b1, 2'd2, d, 1'b0, acc, emit, od, oe);
      n_vec += 2;
      if (acc !== 1'b0) begin n_err++; $display("FAIL bp_hold_C[%0d]: in_ready %b expected 0", i, acc); end
      if (od !== 32'hAAAA0001) begin n_err++; $display("FAIL bp_stable[%0d]: got %h expected aaaa0001", i, od); end
      if (acc) qa.push_back(model_a(2'd2, d));
    end
    c_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_cycle(!c_taken, 2'd2, d, 1'b1, acc, emit, od, oe);
      n_vec++;
      if (emit !== 1'b1) begin n_err++; $display("FAIL bp_no_gap[%0d]: out_valid %b expected 1", i, emit); end
      if (emit) begin
        ex = pop_a();
        n_vec++;
        if (od !== ex.d || oe !== ex.e) begin
          n_err++; $display("FAIL bp_order[%0d]: got %h/%b expected %h/%b", i, od, oe, ex.d, ex.e);
        end
      end
      if (acc) begin
        qa.push_back(model_a(2'd2, d));
        c_taken = 1'b1;
      end
    end
    a_in_valid = 1'b0;
    n_vec += 2;
    if (qa.size() != 0)       begin n_err++; $display("FAIL bp_drain: %0d beats left expected 0", qa.size()); end
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: out_valid %b expected 0", a_out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [95:0] d;
    logic [1:0] sel;
    logic acc, emit, oe;
    logic [31:0] od;
    exp32_t ex;
    d = 96'({$urandom(), $urandom(), $urandom()});
    a_cycle(1'b1, 2'd1, d, 1'b0, acc, emit, od, oe);
    if (acc) qa.push_back(model_a(2'd1, d));
    for (int i = 0; i < 10; i++) begin
      d   = 96'({$urandom(), $urandom(), $urandom()});
      sel = 2'($urandom_range(0, 2));
      n_vec += 2;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
        n_err++; $display("FAIL sim_occ1[%0d]: ready/valid %b%b expected 11", i, a_in_ready, a_out_valid);
      end
      a_cycle(1'b1, sel, d, 1'b1, acc, emit, od, oe);
      if (!(acc && emit)) begin
        n_err++; $display("FAIL sim_both[%0d]: acc/emit %b%b expected 11", i, acc, emit);
      end
      if (emit) begin
        ex = pop_a();
        if (od !== ex.d || oe !== ex.e) begin
          n_err++; $display("FAIL sim_beat[%0d]: got %h/%b expected %h/%b", i, od, oe, ex.d, ex.e);
        end
      end
      if (acc) qa.push_back(model_a(sel, d));
    end
    a_cycle(1'b0, 2'd0, d, 1'b1, acc, emit, od, oe);
    ex = pop_a();
    n_vec += 2;
    if (!emit || od !== ex.d || oe !== ex.e) begin
      n_err++; $display("FAIL sim_last: got %b %h/%b expected 1 %h/%b", emit, od, oe, ex.d, ex.e);
    end
    if (qa.size() != 0) begin n_err++; $display("FAIL sim_drain: %0d beats left expected 0", qa.size()); end
  endtask

  task automatic test_async_reset();
    logic [95:0] d;
    logic acc, emit, oe;
    logic [31:0] od;
    exp32_t ex;
    d = {32'h0000AAAA, 32'h5555FFFF, 32'h9999EEEE};
    a_cycle(1'b1, 2'd0, d, 1'b0, acc, emit, od, oe);
    a_cycle(1'b1, 2'd1, d, 1'b0, acc, emit, od, oe);
    a_in_valid = 1'b0;
    n_vec++;
    if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL ar_full: in_ready %b expected 0", a_in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid: got %b expected 0", a_out_valid); end
    if (a_out_data !== 32'h0) begin n_err++; $display("FAIL ar_out_data: got %h expected 0", a_out_data); end
    if (a_out_err !== 1'b0)   begin n_err++; $display("FAIL ar_out_err: got %b expected 0", a_out_err); end
    if (a_in_ready !== 1'b1)  begin n_err++; $display("FAIL ar_in_ready: got %b expected 1", a_in_ready); end
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_cycle(1'b1, 2'd2, d, 1'b1, acc, emit, od, oe);
    if (acc) qa.push_back(model_a(2'd2, d));
    n_vec++;
    if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL ar_latency: out_valid %b expected 1", a_out_valid); end
    a_cycle(1'b0, 2'd0, d, 1'b1, acc, emit, od, oe);
    ex = pop_a();
    n_vec++;
    if (!emit || od !== ex.d || oe !== ex.e) begin
      n_err++; $display("FAIL ar_first_beat: got %b %h/%b expected 1 %h/%b", emit, od, oe, ex.d, ex.e);
    end
  endtask

  task automatic test_stress();
    logic acc, emit, pstall, pe;
    logic [15:0] pd;
    exp16_t ex;
    pstall = 1'b0;
    pd     = '0;
    pe     = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      c_in_valid  = ($urandom_range(0, 9) < 7);
      c_in_sel    = 3'($urandom_range(0, 7));
      c_in_data   = 80'({$urandom(), $urandom(), $urandom()});
      c_out_ready = ($urandom_range(0, 9) < 6);
      n_vec += 2;
      if (c_in_ready !== (qc.size() < 2) || c_out_valid !== (qc.size() > 0)) begin
        n_err++;
        $display("FAIL st_flow[%0d]: ready/valid %b%b with %0d buffered", cyc, c_in_ready, c_out_valid, qc.size());
      end
      if (pstall && (c_out_valid !== 1'b1 || c_out_data !== pd || c_out_err !== pe)) begin
        n_err++;
        $display("FAIL st_stall[%0d]: got %b %h/%b expected 1 %h/%b", cyc, c_out_valid, c_out_data, c_out_err, pd, pe);
      end
      acc  = c_in_valid && c_in_ready;
      emit = c_out_valid && c_out_ready;
      if (emit) begin
        n_vec++;
        if (qc.size() == 0) begin
          n_err++; $display("FAIL st_extra[%0d]: unexpected beat %h/%b", cyc, c_out_data, c_out_err);
        end else begin
          ex = qc.pop_front();
          if (c_out_data !== ex.d || c_out_err !== ex.e) begin
            n_err++; $display("FAIL st_beat[%0d]: got %h/%b expected %h/%b", cyc, c_out_data, c_out_err, ex.d, ex.e);
          end
        end
      end
      pstall = c_out_valid && !c_out_ready;
      pd     = c_out_data;
      pe     = c_out_err;
      if (acc) qc.push_back(model_c(c_in_sel, c_in_data));
      @(posedge clk);
      @(negedge clk);
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    for (int i = 0; i < 8 && qc.size() != 0; i++) begin
      if (c_out_valid) begin
        ex = qc.pop_front();
        n_vec++;
        if (c_out_data !== ex.d || c_out_err !== ex.e) begin
          n_err++; $display("FAIL st_drain_beat[%0d]: got %h/%b expected %h/%b", i, c_out_data, c_out_err, ex.d, ex.e);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_vec += 2;
    if (qc.size() != 0)       begin n_err++; $display("FAIL st_loss: %0d beats never emitted", qc.size()); end
    if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL st_dup: out_valid %b after drain expected 0", c_out_valid); end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_sel = '0; c_in_data = '0; c_out_ready = 1'b1;
    test_reset();
    test_pass_through();
    test_out_of_range();
    test_back_pressure();
    test_simultaneous();
    test_async_reset();
    test_stress();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/result_select_stage.md
# result_select_stage

Parametrised N-way result selector with a registered, flow-controlled output stage for the datapath's writeback/forwarding paths. Each accepted beat picks one of N_IN source words by a binary select. Out-of-range selects yield a defined zero result plus an error flag. The result is delivered through a 2-entry skid buffer so that valid/ready back-pressure never drops or duplicates a beat.

## Interface

Parameters:
- WIDTH, 32, data width of every source and of the result
- N_IN, 3, number of source inputs (2..16)
- SEL_W, $clog2(N_IN), select width (derived; never overridden)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_sel  input  SEL_W  binary index of the selected source
- in_data  input  N_IN x WIDTH  packed source words; source k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  selected word
- out_err  output  1  beat was produced from an out-of-range select (in_sel >= N_IN)

## Operation

- Accept: in_valid && in_ready. Select is combinational and decoded only on accept:
  - in_sel < N_IN: result = source[in_sel], err = 0
  - otherwise: result = 0, err = 1
- Every select value has a defined result; the decode contains no latches or undefined outputs.
- Emit: out_valid && out_ready.
- Buffer: main register (drives out_*) plus one skid register; occupancy 0, 1, or 2.
  - Occupancy 0: accept writes main.
  - Occupancy 1, main consumed and accept in the same cycle: accept overwrites main.
  - Occupancy 1, main not consumed and accept: accept writes skid, occupancy becomes 2.
  - Occupancy 2 and emit: skid moves to main, occupancy becomes 1.
- in_ready = (occupancy < 2), driven from a registered full flag with no combinational path from out_ready. in_ready is low only at occupancy 2.
- out_valid = (occupancy > 0).
- Beats leave in acceptance order. No beat is dropped or duplicated.
- in_sel and in_data are ignored when in_valid = 0.

## Timing

- Reset (rst_n low, asynchronous): occupancy = 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 1. Skid contents are cleared to 0.
- Reset mid-operation discards all buffered beats immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge t is visible on out_* after edge t; it can be consumed at edge t+1 at the earliest.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- Back-pressure: out_ready low for one cycle costs no bubble. in_ready drops the cycle after occupancy reaches 2.
- Simultaneous accept and emit at occupancy 2: not possible, because in_ready = 0.
- Simultaneous accept and emit at occupancy 1: occupancy stays 1; main takes the new beat.
- out_data and out_err are held stable while out_valid && !out_ready.

## Structure

- Package result_select_pkg:
  - RS_WIDTH_DEFAULT = 32
  - RS_N_IN_DEFAULT = 3
  - RS_ERR_DATA = '0 (value substituted on out-of-range select)
  - typedef rs_beat_t, a struct of data and err
- Sub-module rs_skid_buffer: generic 2-entry valid/ready buffer over rs_beat_t.
- The top module holds only the select decode and instantiates rs_skid_buffer.

## Test plan

- Reset then pass-through, N_IN=3: sources 0x11111111 / 0x22222222 / 0x33333333, in_sel = 0, 1, 2 on consecutive cycles, out_ready = 1.
  - Required: out_data 0x11111111, 0x22222222, 0x33333333 on the three cycles after each accept; out_err = 0; in_ready stays 1.
- Out-of-range: N_IN=3, in_sel = 3.
  - Required: out_data = 0, out_err = 1, one beat.
  - Repeat at N_IN=4 with in_sel = 3: required out_data = source 3, out_err = 0.
- Back-pressure: hold out_ready = 0 and offer beats A, B, C.
  - Required: A and B accepted; in_ready falls after B; C is held upstream.
  - Then raise out_ready: required out order A, B, C with no gaps.
- Simultaneous events: at occupancy 1 assert accept and emit in the same cycle for 10 cycles.
  - Required: occupancy stays 1, in_ready stays 1, all 10 beats emitted in order.
- Asynchronous reset mid-operation: assert rst_n low between edges at occupancy 2.
  - Required: out_valid = 0, out_data = 0, out_err = 0, in_ready = 1 immediately, before the next edge.
  - Required: after release, the first new beat appears with 1-cycle latency.
- Random stress, N_IN=5, WIDTH=16: random valid/ready/select over 10k cycles.
  - Required: scoreboard match of every beat; no loss or duplication; out_* stable while stalled.
